// File: rtl/sipo_deserializer_if.sv
// Receive-side bundle for the SIPO deserializer: serial input, control,
// parallel valid/ready output and status.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             clear;
    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CNT_W-1:0] bit_cnt;
    logic             busy;
    logic             overrun;

    modport master (
        output clear, sin, sin_valid, dir, dout_ready,
        input  dout, dout_valid, bit_cnt, busy, overrun
    );

    modport slave (
        input  clear, sin, sin_valid, dir, dout_ready,
        output dout, dout_valid, bit_cnt, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with a collecting shift register and an
// output holding register behind a valid/ready handshake.
//
//  state (collect) | meaning
//  IDLE            | no partial word, bit_cnt = 0
//  SHIFT           | partial word in progress, dir_q frozen
//  state (output)  | meaning
//  EMPTY           | dout holds no unconsumed word
//  FULL            | dout holds a word waiting for dout_ready
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sipo_deserializer_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic { IDLE, SHIFT } col_state_t;
    typedef enum logic { EMPTY, FULL } out_state_t;

    col_state_t       col_state_q, col_state_d;
    out_state_t       out_state_q, out_state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             overrun_q, overrun_d;

    logic             dir_eff;
    logic [WIDTH-1:0] shreg_next;
    logic             word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_state_q <= IDLE;
            out_state_q <= EMPTY;
            shreg_q     <= '0;
            dout_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            col_state_q <= col_state_d;
            out_state_q <= out_state_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        col_state_d = col_state_q;
        out_state_d = out_state_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;

        // The first bit of a word uses the live dir; later bits use the latched copy.
        dir_eff    = (col_state_q == IDLE) ? bus.dir : dir_q;
        shreg_next = dir_eff ? {bus.sin, shreg_q[WIDTH-1:1]}
                             : {shreg_q[WIDTH-2:0], bus.sin};

        if (bus.sin_valid) begin
            if (col_state_q == IDLE) begin
                dir_d = bus.dir;
            end
            shreg_d = shreg_next;
            if (cnt_q == LAST_BIT) begin
                cnt_d       = '0;
                col_state_d = IDLE;
                word_done   = 1'b1;
            end else begin
                cnt_d       = cnt_q + 1'b1;
                col_state_d = SHIFT;
            end
        end

        if (word_done) begin
            if (out_state_q == EMPTY || bus.dout_ready) begin
                dout_d      = shreg_next;
                out_state_d = FULL;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_state_q == FULL && bus.dout_ready) begin
            out_state_d = EMPTY;
        end

        if (bus.clear) begin
            col_state_d = IDLE;
            out_state_d = EMPTY;
            shreg_d     = '0;
            dout_d      = '0;
            cnt_d       = '0;
            dir_d       = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (out_state_q == FULL);
    assign bus.bit_cnt    = cnt_q;
    assign bus.busy       = (cnt_q != '0);
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH = 4) with a scoreboard of
// expected delivered words.
module tb_sipo_deserializer;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] sb[$];

    sipo_deserializer_if #(.WIDTH(WIDTH)) bus ();

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        tick();
        bus.sin_valid = 1'b0;
    endtask

    // Serializer model: dir 0 sends MSB first, dir 1 sends LSB first.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic d, input int maxgap);
        int idx;
        bus.dir = d;
        for (int i = 0; i < WIDTH; i++) begin
            if (i > 0 && maxgap > 0) begin
                int g;
                g = $urandom_range(maxgap, 0);
                for (int k = 0; k < g; k++) tick();
            end
            idx = d ? i : (WIDTH - 1 - i);
            send_bit(w[idx]);
        end
    endtask

    task automatic check_word(input string tag);
        logic [WIDTH-1:0] exp;
        chk({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk({tag, "_dout"}, 32'(bus.dout), 32'(exp));
        end
    endtask

    initial begin
        bus.clear      = 1'b0;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.dir        = 1'b0;
        bus.dout_ready = 1'b1;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // Left shift, 1,0,1,1 back to back
        bus.dir = 1'b0;
        sb.push_back(4'b1011);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("left_cnt3", 32'(bus.bit_cnt), 32'd3);
        chk("left_busy", 32'(bus.busy), 32'd1);
        chk("left_valid_early", 32'(bus.dout_valid), 32'd0);
        send_bit(1'b1);
        check_word("left");
        chk("left_cnt_wrap", 32'(bus.bit_cnt), 32'd0);
        tick();
        chk("left_valid_drop", 32'(bus.dout_valid), 32'd0);
        chk("left_dout_hold", 32'(bus.dout), 32'hB);

        // Right shift, same bit sequence 1,0,1,1
        sb.push_back(4'b1101);
        send_word(4'b1101, 1'b1, 0);
        check_word("right");
        tick();

        // dir flips mid-word: word stays MSB-first
        sb.push_back(4'b0110);
        bus.dir = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        bus.dir = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        check_word("dirflip");
        sb.push_back(4'b0011);
        send_word(4'b0011, 1'b1, 0);
        check_word("dirnext");
        tick();

        // Backpressure and overrun
        bus.dout_ready = 1'b0;
        sb.push_back(4'hA);
        send_word(4'hA, 1'b0, 0);
        check_word("bp_first");
        chk("bp_ovr0", 32'(bus.overrun), 32'd0);
        send_word(4'h5, 1'b0, 0);
        chk("bp_dout_kept", 32'(bus.dout), 32'hA);
        chk("bp_valid_kept", 32'(bus.dout_valid), 32'd1);
        chk("bp_ovr_set", 32'(bus.overrun), 32'd1);
        chk("bp_cnt", 32'(bus.bit_cnt), 32'd0);
        bus.dout_ready = 1'b1;
        tick();
        chk("bp_valid_drop", 32'(bus.dout_valid), 32'd0);
        chk("bp_ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_ovr", 32'(bus.overrun), 32'd0);
        chk("clr_dout", 32'(bus.dout), 32'd0);

        // Completion in the same cycle the held word is consumed
        bus.dout_ready = 1'b0;
        sb.push_back(4'h3);
        send_word(4'h3, 1'b0, 0);
        check_word("sim_held");
        sb.push_back(4'hC);
        bus.dir = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("sim_hold_dout", 32'(bus.dout), 32'h3);
        bus.dout_ready = 1'b1;
        send_bit(1'b0);
        check_word("sim_new");
        chk("sim_ovr", 32'(bus.overrun), 32'd0);
        tick();

        // clear wins over a completing bit
        bus.dir = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        bus.clear = 1'b1;
        send_bit(1'b1);
        bus.clear = 1'b0;
        chk("clrbit_valid", 32'(bus.dout_valid), 32'd0);
        chk("clrbit_dout", 32'(bus.dout), 32'd0);
        chk("clrbit_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("clrbit_busy", 32'(bus.busy), 32'd0);

        // Gapped input
        for (int n = 0; n < 6; n++) begin
            logic [WIDTH-1:0] w;
            logic             d;
            w = (n == 5) ? 4'hE : WIDTH'($urandom_range(15, 0));
            d = 1'($urandom_range(1, 0));
            sb.push_back(w);
            send_word(w, d, 3);
            check_word($sformatf("gap%0d", n));
            tick();
        end

        // Asynchronous reset in mid-word, no clock edge involved
        bus.dir = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_dout", 32'(bus.dout), 32'd0);
        chk("arst_valid", 32'(bus.dout_valid), 32'd0);
        chk("arst_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("arst_ovr", 32'(bus.overrun), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        sb.push_back(4'h6);
        send_word(4'h6, 1'b0, 0);
        check_word("post_rst");
        chk("post_rst_ovr", 32'(bus.overrun), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver that rebuilds WIDTH-bit words from a bit stream produced by a left-shifting (MSB-first) or right-shifting (LSB-first) serializer.
- Sits at the receive end of the team's serial shift links and hands complete words downstream over a valid/ready handshake.
- Double-buffered: a shift register collects bits while an output holding register waits for the consumer.

Parameters:
- WIDTH, 4, word width in bits; legal values are 2 to 32.
- CNT_W, $clog2(WIDTH), width of the bit counter; this is a localparam derived from WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all state; same effect as reset, applied on the clock edge.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge.
- dir  input  1  shift direction: 0 = left shift, MSB first; 1 = right shift, LSB first. Latched on the first bit of each word.
- dout  output  WIDTH  assembled word, stable while dout_valid = 1.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout.
- bit_cnt  output  CNT_W  number of bits collected in the current partial word.
- busy  output  1  a partial word is in progress (bit_cnt != 0).
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst_n = 0, asynchronous) and clear = 1 (synchronous) both zero the following:
  - shift register, dout, dout_valid, bit_cnt, busy, overrun, latched direction.
  - clear takes priority over every other input in the same cycle.
- Collect FSM, states IDLE (bit_cnt = 0) and SHIFT:
  - IDLE + sin_valid: latch dir into dir_q, shift in sin, bit_cnt = 1, go to SHIFT.
  - SHIFT + sin_valid: shift in sin, bit_cnt + 1.
  - On the WIDTH-th bit: bit_cnt wraps to 0, go to IDLE, generate a "word complete" event.
  - No sin_valid: hold state; gaps between bits are unlimited.
  - dir changes while in SHIFT are ignored until the next word starts.
- Shift rules:
  - dir_q = 0: shreg <= {shreg[WIDTH-2:0], sin}, so the first bit lands in the MSB.
  - dir_q = 1: shreg <= {sin, shreg[WIDTH-1:1]}, so the first bit lands in the LSB.
  - The word is built from the shift register value including the bit sampled this cycle.
- Output side, states EMPTY and FULL:
  - Word complete while EMPTY, or while FULL with dout_ready = 1 in the same cycle:
    - dout <= assembled word, dout_valid = 1 after that edge.
    - Latency is one edge from the final sampled bit to dout_valid high.
  - dout_valid = 1 and dout_ready = 1 with no completion: dout_valid drops to 0 after the edge; dout keeps its last value.
  - Word complete while dout_valid = 1 and dout_ready = 0:
    - the new word is discarded; dout keeps the old word.
    - overrun is set and stays set until reset or clear.
    - bit collection carries on normally.
- dout never changes while dout_valid = 1 && dout_ready = 0.
- busy = (bit_cnt != 0); it is a registered value, not a separate flop.
- Reset asserted mid-word: the partial word is lost with no output and no overrun. After release the block starts in IDLE/EMPTY.
- No combinational path from inputs to outputs; every output is registered.

Test Plan:
- Reset → outputs: assert rst_n = 0 mid-stream → dout = 0, dout_valid = 0, bit_cnt = 0, overrun = 0 with no clock edge needed; after release, the next 4 bits form a fresh word.
- Left mode, WIDTH = 4: dir = 0, bits 1,0,1,1 on consecutive cycles, dout_ready = 1 → dout = 4'b1011 with dout_valid high exactly one cycle, one edge after the 4th bit.
- Right mode: dir = 1, same bits 1,0,1,1 → dout = 4'b1101.
- dir toggled to 1 after the 2nd bit of a dir = 0 word → word still assembled MSB-first; the next word uses dir = 1.
- Backpressure and overrun:
  - dout_ready = 0; send words 4'hA then 4'h5 → dout stays 4'hA, overrun = 1.
  - Raise dout_ready → dout_valid drops; overrun stays 1 until clear.
- Simultaneous events, collection side: 4'h3 held in dout; 4th bit of 4'hC arrives in the same cycle dout_ready = 1 → dout = 4'hC, dout_valid stays 1, overrun = 0.
- Simultaneous events, clear: clear = 1 together with a completing sin_valid bit → everything zeroed, no word delivered.
- Gapped input: random sin_valid gaps within a word give the same result as gap-free input.
